ddr3_request_arbiter: RTL

DDR3_REQUEST_ARBITER -- requirements
Module: ddr3_request_arbiter

---
 rtl/ddr3_request_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ddr3_request_arbiter.sv
// Two-requester round-robin arbiter in front of a DDR3 user port: one command in flight at a time.
// Define ARB_WATCHDOG_EN to abort stalled transactions after TIMEOUT_CYCLES with a timeout_err pulse.
module ddr3_request_arbiter #(
  parameter int ADDRESS_BITWIDTH      = 13,
  parameter int BANK_ADDRESS_BITWIDTH = 4,
  parameter int DQ_BITWIDTH           = 8,
  parameter int TIMEOUT_CYCLES        = 1024,
  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  input  logic [1:0]               req_write,
  input  logic [2*AW-1:0]          req_address,
  input  logic [2*DQ_BITWIDTH-1:0] req_wdata,
  output logic [1:0]               req_ready,
  output logic [1:0]               rsp_valid,
  output logic [DQ_BITWIDTH-1:0]   rsp_rdata,
  output logic [1:0]               timeout_err,
  output logic                     write_enable,
  output logic                     read_enable,
  output logic [AW-1:0]            i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]   i_user_data,
  input  logic [DQ_BITWIDTH-1:0]   o_user_data,
  input  logic                     ctrl_ready,
  input  logic                     ctrl_rdata_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2} state_t;

  state_t                   state, state_next;
  logic                     last_grant, grant_q, grant_sel, take, done, abort;
  logic                     cmd_write;
  logic [AW-1:0]            cmd_addr;
  logic [DQ_BITWIDTH-1:0]   cmd_wdata;
  logic [1:0]               rsp_valid_q;
  logic [DQ_BITWIDTH-1:0]   rsp_rdata_q;

  // Handshake: a command transfers in the cycle where req_valid[n] and req_ready[n] are both high;
  // req_ready is offered only in IDLE, to a single requester, and is forced low while reset is high.
  assign grant_sel = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign take      = (state == IDLE) && (|req_valid) && !reset;
  assign done      = ((state == ISSUE) && ctrl_ready) || ((state == WAIT_RD) && ctrl_rdata_valid);

`ifdef ARB_WATCHDOG_EN
  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_count;
  logic [1:0]     timeout_q;

  assign abort = (state != IDLE) && !done && (wd_count == WD_LAST);

  // Counter sits at zero in IDLE, so the first ISSUE cycle always sees a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_count  <= '0;
      timeout_q <= '0;
    end else begin
      timeout_q <= '0;
      if (state == IDLE) wd_count <= '0;
      else               wd_count <= wd_count + WDW'(1);
      if (abort) timeout_q[grant_q] <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 2'b00;
`endif

  always_comb begin
    state_next   = state;
    req_ready    = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          req_ready[grant_sel] = 1'b1;
          state_next           = ISSUE;
        end
      end
      ISSUE: begin
        write_enable = cmd_write;
        read_enable  = ~cmd_write;
        if (ctrl_ready) state_next = cmd_write ? IDLE : WAIT_RD;
        else if (abort) state_next = IDLE;
      end
      WAIT_RD: begin
        if (ctrl_rdata_valid || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_q     <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_next;
      rsp_valid_q <= '0;
      if (take) begin
        last_grant <= grant_sel;
        grant_q    <= grant_sel;
        cmd_write  <= req_write[grant_sel];
        cmd_addr   <= grant_sel ? req_address[2*AW-1:AW] : req_address[AW-1:0];
        cmd_wdata  <= grant_sel ? req_wdata[2*DQ_BITWIDTH-1:DQ_BITWIDTH] : req_wdata[DQ_BITWIDTH-1:0];
      end
      if ((state == WAIT_RD) && ctrl_rdata_valid) begin
        rsp_valid_q[grant_q] <= 1'b1;
        rsp_rdata_q          <= o_user_data;
      end
    end
  end

  assign i_user_data_address = cmd_addr;
  assign i_user_data         = cmd_wdata;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_rdata           = rsp_rdata_q;

endmodule
